// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage leading-zero normalizer with valid/ready flow.
// Define NORM_UFLOW_SAT_EN to saturate exponent underflow and raise out_uflow.
module norm_shift_pipe #(
  parameter int N = 64,
  parameter int E = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mant,
  input  logic [E-1:0] in_exp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_mant,
  output logic [E-1:0] out_exp,
  output logic         out_zero,
  output logic         out_uflow
);
  localparam int S = $clog2(N);

  logic         r_v1;
  logic         r_v2;
  logic [N-1:0] r_m1;
  logic [E-1:0] r_e1;
  logic [S:0]   r_lzc1;
  logic [N-1:0] r_m2;
  logic [E-1:0] r_e2;
  logic         r_z2;
  logic         r_u2;

  logic         w_ld1;
  logic         w_ld2;
  logic [S:0]   w_lzc;
  logic [N-1:0] w_mant;
  logic [E-1:0] w_exp;
  logic         w_uflow;

  assign in_ready = ~r_v1 | ~r_v2 | out_ready;
  assign w_ld1    = in_valid & in_ready;
  assign w_ld2    = r_v1 & (~r_v2 | out_ready);

  // last set bit scanned upward wins, so this finds the MSB
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < N; i++) begin
      if (in_mant[i]) w_lzc = (S+1)'(N - 1 - i);
    end
  end

  assign w_mant = r_m1 << r_lzc1;

`ifdef NORM_UFLOW_SAT_EN
  logic [E:0] w_diff;

  assign w_diff  = {r_e1[E-1], r_e1}
                 - {{(E-S){1'b0}}, r_lzc1};
  assign w_uflow = w_diff[E] ^ w_diff[E-1];
  assign w_exp   = w_uflow ? {1'b1, {(E-1){1'b0}}}
                           : w_diff[E-1:0];
`else
  assign w_uflow = 1'b0;
  assign w_exp   = r_e1 - {{(E-S-1){1'b0}}, r_lzc1};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (in_ready) r_v1 <= in_valid;
      if (~r_v2 | out_ready) r_v2 <= r_v1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld1) begin
      r_m1   <= in_mant;
      r_e1   <= in_exp;
      r_lzc1 <= w_lzc;
    end
    if (w_ld2) begin
      r_m2 <= w_mant;
      r_e2 <= w_exp;
      r_z2 <= ~|r_m1;
      r_u2 <= w_uflow;
    end
  end

  // data is masked while empty so reset reads all zeros
  assign out_valid = r_v2;
  assign out_mant  = r_v2 ? r_m2 : '0;
  assign out_exp   = r_v2 ? r_e2 : '0;
  assign out_zero  = r_v2 & r_z2;
  assign out_uflow = r_v2 & r_u2;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: directed literals plus randomized traffic
// checked against a queue-based behavioural model.
module tb_norm_shift_pipe;
  localparam int N  = 64;
  localparam int E  = 10;
  localparam int N2 = 48;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_mant;
  logic [E-1:0] in_exp;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_mant;
  logic [E-1:0] out_exp;
  logic         out_zero;
  logic         out_uflow;

  logic          b_iv;
  logic          b_ir;
  logic [N2-1:0] b_im;
  logic [E-1:0]  b_ie;
  logic          b_ov;
  logic          b_or;
  logic [N2-1:0] b_om;
  logic [E-1:0]  b_oe;
  logic          b_oz;
  logic          b_ou;

  norm_shift_pipe #(.N(N), .E(E)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_uflow(out_uflow)
  );

  norm_shift_pipe #(.N(N2), .E(E)) u_dut48 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_mant(b_im), .in_exp(b_ie),
    .out_valid(b_ov), .out_ready(b_or),
    .out_mant(b_om), .out_exp(b_oe),
    .out_zero(b_oz), .out_uflow(b_ou)
  );

  typedef struct packed {
    logic [N-1:0] m;
    logic [E-1:0] e;
    logic         z;
    logic         u;
  } res_t;

  typedef struct packed {
    logic [N-1:0] m;
    logic [E-1:0] e;
    longint       acc;
  } word_t;

  int     total = 0;
  int     bad = 0;
  longint nedge = 0;
  word_t  q[$];
  int     popped = 0;
  int     run = 0;
  int     maxrun = 0;
  logic   prev_stall = 1'b0;
  logic [N-1:0] pm;
  logic [E-1:0] pe;
  logic         pz;
  logic         pu;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Normalization from first principles: count leading zeros,
  // shift, subtract, then wrap or saturate in integer arithmetic.
  function automatic res_t ref_f(input logic [N-1:0] m,
                                 input logic [E-1:0] e);
    res_t r;
    int   lz;
    int   d;
    int   ei;
    bit   found;
    lz = 0;
    found = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1;
        else lz++;
      end
    end
    if (!found) lz = 0;
    ei = $signed(e);
    d = ei - lz;
    r.u = 1'b0;
`ifdef NORM_UFLOW_SAT_EN
    if (d < -(1 << (E - 1))) begin
      d = -(1 << (E - 1));
      r.u = 1'b1;
    end
`endif
    r.m = m << lz;
    r.e = d[E-1:0];
    r.z = (m == '0);
    return r;
  endfunction

  always @(posedge clk) nedge <= nedge + 1;

  always @(negedge clk) begin
    logic  ev;
    logic  er;
    res_t  r;
    word_t w;
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_mant", out_mant, 64'd0);
      chk("rst_out_exp", 64'(out_exp), 64'd0);
      chk("rst_out_zero", 64'(out_zero), 64'd0);
      chk("rst_out_uflow", 64'(out_uflow), 64'd0);
      q.delete();
      prev_stall = 1'b0;
      run = 0;
    end else begin
      ev = (q.size() > 0) && (nedge >= q[0].acc + 2);
      er = (q.size() < 2) || out_ready;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(er));
      if (ev) begin
        r = ref_f(q[0].m, q[0].e);
        chk("out_mant", out_mant, r.m);
        chk("out_exp", 64'(out_exp), 64'(r.e));
        chk("out_zero", 64'(out_zero), 64'(r.z));
        chk("out_uflow", 64'(out_uflow), 64'(r.u));
      end
      if (prev_stall) begin
        chk("hold_mant", out_mant, pm);
        chk("hold_exp", 64'(out_exp), 64'(pe));
        chk("hold_zero", 64'(out_zero), 64'(pz));
        chk("hold_uflow", 64'(out_uflow), 64'(pu));
      end
      prev_stall = out_valid && !out_ready;
      pm = out_mant;
      pe = out_exp;
      pz = out_zero;
      pu = out_uflow;
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (ev && out_ready) begin
        void'(q.pop_front());
        popped++;
      end
      if (in_valid && er) begin
        w.m = in_mant;
        w.e = in_exp;
        w.acc = nedge;
        q.push_back(w);
      end
    end
  end

  task automatic send_chk(input string nm, input logic [N-1:0] m,
                          input logic [E-1:0] e, input logic [N-1:0] xm,
                          input logic [E-1:0] xe, input logic xz,
                          input logic xu);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_mant = m;
    in_exp = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_mant"}, out_mant, xm);
    chk({nm, "_exp"}, 64'(out_exp), 64'(xe));
    chk({nm, "_zero"}, 64'(out_zero), 64'(xz));
    chk({nm, "_uflow"}, 64'(out_uflow), 64'(xu));
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while ((out_valid || q.size() > 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_drain"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int   base;
    int   nacc;
    logic acc_now;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_mant = '0;
    in_exp = '0;
    out_ready = 1'b1;
    b_iv = 1'b0;
    b_im = '0;
    b_ie = '0;
    b_or = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;

    send_chk("one", 64'h1, 10'd5,
             64'h8000_0000_0000_0000, 10'h3C6, 1'b0, 1'b0);
    send_chk("zero", 64'h0, 10'h3FD,
             64'h0, 10'h3FD, 1'b1, 1'b0);
`ifdef NORM_UFLOW_SAT_EN
    send_chk("uflow", 64'h1, 10'h20C,
             64'h8000_0000_0000_0000, 10'h200, 1'b0, 1'b1);
`else
    send_chk("uflow", 64'h1, 10'h20C,
             64'h8000_0000_0000_0000, 10'd461, 1'b0, 1'b0);
`endif
    send_chk("edge_min", 64'h4000_0000_0000_0000, 10'h201,
             64'h8000_0000_0000_0000, 10'h200, 1'b0, 1'b0);

    @(posedge clk); #1;
    b_iv = 1'b1;
    b_im = 48'h0000_8000_0000;
    b_ie = 10'd0;
    chk("n48_ready", 64'(b_ir), 64'd1);
    @(posedge clk); #1;
    b_iv = 1'b0;
    @(posedge clk); #1;
    chk("n48_valid", 64'(b_ov), 64'd1);
    chk("n48_mant", 64'(b_om), 64'h8000_0000_0000);
    chk("n48_exp", 64'(b_oe), 64'h3F0);
    chk("n48_zero", 64'(b_oz), 64'd0);
    chk("n48_uflow", 64'(b_ou), 64'd0);

    maxrun = 0;
    base = popped;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_mant = rand64() >> $urandom_range(0, 63);
      in_exp = E'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain("b2b");
    chk("b2b_run", 64'(maxrun), 64'd8);
    chk("b2b_count", 64'(popped - base), 64'd8);

    nacc = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mant = rand64();
    in_exp = E'($urandom);
    for (int i = 0; i < 5; i++) begin
      acc_now = in_ready;
      if (acc_now) nacc++;
      @(posedge clk); #1;
      if (acc_now) begin
        in_mant = rand64() >> $urandom_range(0, 63);
        in_exp = E'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("stall_accepts", 64'(nacc), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_drain("stall");
    chk("stall_delivered", 64'(popped - base), 64'd10);

    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mant = rand64();
    in_exp = E'($urandom);
    @(posedge clk); #1;
    in_mant = rand64();
    in_exp = E'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_chk("post_rst", 64'h0000_0F00_0000_0000, 10'd7,
             64'hF000_0000_0000_0000, 10'h3F3, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) < (i / 1000) + 1);
      in_mant = rand64() >> $urandom_range(0, 64);
      in_exp = E'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
